// File: rtl/comparador_serial_izqader.sv
// -----------------------------------------------------------------------------
// comparador_serial_izqader
//
// Serial MSB-first magnitude comparator. On an accepted start the operands are
// latched into shift registers and resolved DIGIT bits per clock, most
// significant digit first. The verdict uses the f/g flag pair of the iterative
// comparator cells: f=1 -> A>B, g=1 -> A<B, f=g=0 -> A==B.
//
// Parameters:
//   WIDTH  operand width in bits (multiple of DIGIT, >= DIGIT)
//   DIGIT  bits resolved per clock
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   start request, only honoured while idle
//   A, B   in   unsigned operands, sampled on the accepted start edge
//   busy   out  high while a comparison is in progress
//   done   out  one-cycle pulse, f/g are final
//   f      out  A>B flag
//   g      out  A<B flag
//
// Build option:
//   COMP_EARLY_EXIT_EN  when defined, the comparison terminates on the edge
//                       where the first differing digit is found.
// -----------------------------------------------------------------------------
module comparador_serial_izqader #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             f,
    output logic             g
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_param_err
            $error("comparador_serial_izqader: WIDTH must be a multiple of DIGIT and >= DIGIT");
        end
    endgenerate

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             f_q, f_d;
    logic             g_q, g_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] da, db;
    logic             undecided;
    logic             finish;

    assign da        = sa_q[WIDTH-1 -: DIGIT];
    assign db        = sb_q[WIDTH-1 -: DIGIT];
    assign undecided = !f_q && !g_q;

`ifdef COMP_EARLY_EXIT_EN
    // Stop on the last digit, or as soon as an undecided comparison sees a difference.
    assign finish = (cnt_q == CW'(N - 1)) || (undecided && (da != db));
`else
    assign finish = (cnt_q == CW'(N - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            f_q     <= 1'b0;
            g_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            g_q     <= g_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
        g_d     = g_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    cnt_d   = '0;
                    f_d     = 1'b0;
                    g_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                // The first differing digit decides; later digits cannot override it.
                if (undecided) begin
                    f_d = (da > db);
                    g_d = (da < db);
                end
                sa_d  = sa_q << DIGIT;
                sb_d  = sb_q << DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (finish) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign f    = f_q;
    assign g    = g_q;

endmodule

// File: tb/tb_comparador_serial_izqader.sv
module tb_comparador_serial_izqader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 0: (8,2)  DUT 1: (8,1)  DUT 2: (8,8)  DUT 3: (16,4)
    logic [3:0]  start_s = '0;
    logic [7:0]  a8 [3];
    logic [7:0]  b8 [3];
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [3:0]  busy_w, done_w, f_w, g_w;

    int W [4] = '{8, 8, 8, 16};
    int D [4] = '{2, 1, 8, 4};

    comparador_serial_izqader #(.WIDTH(8), .DIGIT(2)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .A(a8[0]), .B(b8[0]),
        .busy(busy_w[0]), .done(done_w[0]), .f(f_w[0]), .g(g_w[0]));
    comparador_serial_izqader #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .A(a8[1]), .B(b8[1]),
        .busy(busy_w[1]), .done(done_w[1]), .f(f_w[1]), .g(g_w[1]));
    comparador_serial_izqader #(.WIDTH(8), .DIGIT(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .A(a8[2]), .B(b8[2]),
        .busy(busy_w[2]), .done(done_w[2]), .f(f_w[2]), .g(g_w[2]));
    comparador_serial_izqader #(.WIDTH(16), .DIGIT(4)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start_s[3]), .A(a16), .B(b16),
        .busy(busy_w[3]), .done(done_w[3]), .f(f_w[3]), .g(g_w[3]));

    typedef struct {
        int   id;
        logic f;
        logic g;
        int   due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Edges needed from start to done, from the operand digits.
    function automatic int latency(input int id, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = W[id] / D[id];
`ifdef COMP_EARLY_EXIT_EN
        for (int k = 0; k < n; k++) begin
            int sh;
            logic [15:0] mask, xa, xb;
            sh   = W[id] - (k + 1) * D[id];
            mask = 16'((32'd1 << D[id]) - 1);
            xa   = (a >> sh) & mask;
            xb   = (b >> sh) & mask;
            if (xa != xb) return k + 1;
        end
`endif
        return n;
    endfunction

    // Monitor: sample 1 time unit after the active edge.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (done_w[i]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("unexpected_done_dut%0d", i), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_dut_id", i, e.id);
                    chk($sformatf("f_dut%0d", i), {31'd0, f_w[i]}, {31'd0, e.f});
                    chk($sformatf("g_dut%0d", i), {31'd0, g_w[i]}, {31'd0, e.g});
                    chk($sformatf("latency_dut%0d", i), cyc, e.due);
                    chk($sformatf("busy_at_done_dut%0d", i), {31'd0, busy_w[i]}, 32'd0);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the start edge.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        if (id == 3) begin
            a16 = a; b16 = b;
        end else begin
            a8[id] = a[7:0]; b8[id] = b[7:0];
        end
        start_s[id] = 1'b1;
        e.id  = id;
        e.f   = (a > b);
        e.g   = (a < b);
        e.due = cyc + 1 + latency(id, a, b);
        exp_q.push_back(e);
        @(negedge clk);
        start_s[id] = 1'b0;
    endtask

    task automatic wait_all();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            chk("timeout_pending_results", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            a8[i] = '0; b8[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset_state", {28'd0, busy_w[0], done_w[0], f_w[0], g_w[0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Equal operands and MSB-decided comparison
        issue(0, 16'hA5, 16'hA5); wait_all();
        issue(0, 16'h80, 16'h7F); wait_all();

        // LSB decides: flags stay clear until the last digit
        issue(0, 16'h3C, 16'h3D);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("lsb_flags_edge%0d", k), {30'd0, f_w[0], g_w[0]}, 32'd0);
        end
        wait_all();

        // Start during busy is ignored; operands changing mid-compare have no effect
        issue(0, 16'h10, 16'h20);
        @(negedge clk);
        start_s[0] = 1'b1; a8[0] = 8'hFF;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_all();
        repeat (8) @(negedge clk);

        // Async reset mid-comparison: no done, everything cleared at once
        a8[0] = 8'h3C; b8[0] = 8'h3D; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk("busy_before_reset", {31'd0, busy_w[0]}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_clears", {28'd0, busy_w[0], done_w[0], f_w[0], g_w[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(0, 16'hC3, 16'h5A); wait_all();

        // Back-to-back: start in the done cycle is accepted and clears the flags
        issue(0, 16'hFF, 16'h00);
        begin
            int k = 0;
            while (!done_w[0] && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("b2b_done_seen", {31'd0, done_w[0]}, 32'd1);
        end
        issue(0, 16'h00, 16'h03);
        chk("b2b_accepted_busy", {31'd0, busy_w[0]}, 32'd1);
        chk("b2b_flags_cleared", {30'd0, f_w[0], g_w[0]}, 32'd0);
        wait_all();

        // Parameter sweep with random and near-equal operands
        for (int id = 0; id < 4; id++) begin
            for (int r = 0; r < 6; r++) begin
                logic [15:0] a, b, m;
                m = (W[id] == 16) ? 16'hFFFF : 16'h00FF;
                a = 16'($urandom) & m;
                case (r)
                    0: b = a;
                    1: b = a ^ 16'h0001;
                    default: b = 16'($urandom) & m;
                endcase
                issue(id, a, b);
                wait_all();
            end
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/comparador_serial_izqader.md
# comparador_serial_izqader

Sequential, parametrised left-to-right (MSB-first) magnitude comparator, the multi-cycle successor to the combinational iterative comparator cells. It latches two unsigned WIDTH-bit operands on a start request and resolves them DIGIT bits per clock, most significant digit first. It reports the result on the same f/g flag pair used by the iterative cells: f=1 means A>B, g=1 means A<B, and f=g=0 means A==B. The block sits between the operand registers and the control logic, and trades latency for area when WIDTH is large.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ DIGIT.
- DIGIT, 2, bits resolved per cycle; WIDTH % DIGIT must be 0, otherwise a generate-time error is raised.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  start request; sampled only in IDLE.
- A  input  WIDTH  operand A, unsigned; sampled on the start edge only.
- B  input  WIDTH  operand B, unsigned; sampled on the start edge only.
- busy  output  1  high while in COMPARE.
- done  output  1  one-cycle pulse; result is final.
- f  output  1  A>B flag.
- g  output  1  A<B flag.

## Operation
- N = WIDTH/DIGIT digits. The digit counter is $clog2(N+1) bits wide.
- States:
  - IDLE: waits for start.
  - COMPARE: processes one digit per edge.
- IDLE with start=1 at the edge:
  - Load A and B into shift registers sa and sb.
  - Clear f, g and the counter.
  - Set busy=1 and go to COMPARE.
- COMPARE, each edge:
  - Take the top DIGIT bits of sa and sb as unsigned slices da and db.
  - If f==0 and g==0: f<=(da>db) and g<=(da<db).
  - If either flag is already set, both flags stay frozen.
  - Shift sa and sb left by DIGIT and increment the counter.
- Termination (edge processing digit N-1): go to IDLE, busy<=0, done<=1 for exactly one cycle.
- f and g are never both 1.
- f and g hold their value after done until the next accepted start, which clears them.
- start while busy=1 is ignored. A and B changes during COMPARE have no effect.
- A start in the cycle immediately after done is accepted (back-to-back operation).
- Reset values, asynchronous on rst_n=0, at any time including mid-COMPARE: state=IDLE, busy=0, done=0, f=0, g=0, counter=0, sa=sb=0. An in-flight comparison is discarded and produces no done.

## Timing
- Start edge = edge 0. Digit k (0 = most significant) is processed at edge k+1.
- Base latency: busy rises at edge 0 and falls at edge N. done is high in the cycle following edge N.
- With WIDTH=8 and DIGIT=2, done appears 4 edges after start.
- f/g may change only at COMPARE edges. They are guaranteed final only when done=1.
- Throughput: one comparison per N+1 cycles when back-to-back.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Configuration
- COMP_EARLY_EXIT_EN:
  - Defined: on the COMPARE edge where f or g first becomes 1, the block also goes to IDLE with busy<=0 and done<=1 at that same edge. Latency is k+1 edges, where k is the first differing digit. Equal operands still take N edges.
  - Undefined: every comparison takes exactly N edges regardless of data.
- Result values f/g are identical in both builds.

## Test plan
- Equal operands (WIDTH=8, DIGIT=2): A=8'hA5, B=8'hA5, start pulse → done 4 edges after start, f=0, g=0. Same result with COMP_EARLY_EXIT_EN.
- MSB decides: A=8'h80, B=8'h7F → f=1, g=0. done at edge 4 without the macro; at edge 1 with COMP_EARLY_EXIT_EN.
- LSB decides: A=8'h3C, B=8'h3D → g=1, f=0, done at edge 4 in both builds. Check that f/g stay 0 through edges 1–3.
- Busy protection: start a comparison of 8'h10 vs 8'h20, then assert start with A=8'hFF at edge 2 → request ignored, result g=1, single done pulse.
- Async reset mid-operation: drop rst_n between edges 2 and 3 → busy, done, f, g all 0 immediately, no done pulse. A fresh start after release completes normally.
- Back-to-back and parameter sweep:
  - A start in the cycle after done is accepted, and the flags are cleared at that edge.
  - Repeat random A/B against the reference A>B and A<B for (WIDTH,DIGIT) = (8,1), (8,8), (16,4).
